// File: rtl/data_fill_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : data_fill_writer_if
// Description : Fill / store / read-lookup / bank-write bundle between the
//               L1 data-array write sequencer and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_fill_writer_if #(
  parameter int SET_W = 10,
  parameter int WAY_W = 2,
  parameter int QW    = 128
);
  // Fill request from the memory interface
  logic                   fill_valid;
  logic                   fill_ready;
  logic [SET_W-1:0]       fill_set;
  logic [WAY_W-1:0]       fill_way;
  logic [4*QW-1:0]        fill_line;
  // Store hit from the LSU
  logic                   st_valid;
  logic [SET_W-1:0]       st_set;
  logic [WAY_W-1:0]       st_way;
  logic [1:0]             st_qtr;
  logic [QW-1:0]          st_data;
  // Read-side lookup and stall
  logic [SET_W-1:0]       rd_set;
  logic                   set_busy;
  // Shared quarter-bank write port
  logic                   wr_en;
  logic [3:0]             wr_qsel;
  logic [SET_W+WAY_W-1:0] wr_addr;
  logic [QW-1:0]          wr_data;
  logic                   fill_done;

  modport master (
    output fill_valid, fill_set, fill_way, fill_line,
    output st_valid, st_set, st_way, st_qtr, st_data, rd_set,
    input  fill_ready, set_busy, wr_en, wr_qsel, wr_addr, wr_data, fill_done
  );

  modport slave (
    input  fill_valid, fill_set, fill_way, fill_line,
    input  st_valid, st_set, st_way, st_qtr, st_data, rd_set,
    output fill_ready, set_busy, wr_en, wr_qsel, wr_addr, wr_data, fill_done
  );
endinterface
`default_nettype wire

// File: rtl/data_fill_writer.sv
`default_nettype none
// ============================================================================
// Module      : data_fill_writer
// Description : Funnels 512b line fills (four 128b beats) and single-quarter
//               store hits onto one registered 128b quarter-bank write port.
//               Stores always win the port; a store to the line being filled
//               is merged into the fill buffer so a late beat cannot undo it.
// Revision    : 1.0 - initial release
// ============================================================================
module data_fill_writer #(
  parameter int SET_W = 10,
  parameter int WAY_W = 2,
  parameter int QW    = 128
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  data_fill_writer_if.slave    bus
);

  localparam int c_AW = SET_W + WAY_W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_beat, w_beat_nxt;
  logic [SET_W-1:0] r_fset;
  logic [WAY_W-1:0] r_fway;
  logic [QW-1:0]    r_buf [4];

  logic             r_wr_en,   w_wr_en_nxt;
  logic [3:0]       r_qsel,    w_qsel_nxt;
  logic [c_AW-1:0]  r_addr,    w_addr_nxt;
  logic [QW-1:0]    r_data,    w_data_nxt;
  logic             r_done,    w_done_nxt;

  logic             w_accept;
  logic             w_st_hit_fill;
  logic             w_st_hit_new;

  assign w_accept      = (r_state == S_IDLE) && bus.fill_valid;
  // Store targets the line currently held in the fill buffer
  assign w_st_hit_fill = bus.st_valid && (r_state == S_FILL) &&
                         (bus.st_set == r_fset) && (bus.st_way == r_fway);
  // Store targets the line being accepted this very cycle
  assign w_st_hit_new  = bus.st_valid &&
                         (bus.st_set == bus.fill_set) && (bus.st_way == bus.fill_way);

  // State and beat counter; reset abandons any fill in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next state and next write-port contents; a store pre-empts the due beat
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_wr_en_nxt = 1'b0;
    w_qsel_nxt  = 4'b0000;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;

    if (bus.st_valid) begin
      w_wr_en_nxt = 1'b1;
      w_qsel_nxt  = 4'b0001 << bus.st_qtr;
      w_addr_nxt  = {bus.st_set, bus.st_way};
      w_data_nxt  = bus.st_data;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.fill_valid) begin
          w_state_nxt = S_FILL;
          w_beat_nxt  = 2'd0;
        end
      end
      S_FILL: begin
        if (!bus.st_valid) begin
          w_wr_en_nxt = 1'b1;
          w_qsel_nxt  = 4'b0001 << r_beat;
          w_addr_nxt  = {r_fset, r_fway};
          w_data_nxt  = r_buf[r_beat];
          w_beat_nxt  = r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the target line address when a fill is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fset <= '0;
      r_fway <= '0;
    end else if (w_accept) begin
      r_fset <= bus.fill_set;
      r_fway <= bus.fill_way;
    end
  end

  // Fill buffer: loaded on accept, patched by stores that hit the same line
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int q = 0; q < 4; q++) begin
        if (w_st_hit_new && (bus.st_qtr == 2'(q)))
          r_buf[q] <= bus.st_data;
        else
          r_buf[q] <= bus.fill_line[q*QW +: QW];
      end
    end else if (w_st_hit_fill) begin
      r_buf[bus.st_qtr] <= bus.st_data;
    end
  end

  // Registered bank write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_qsel  <= 4'b0000;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_wr_en <= w_wr_en_nxt;
      r_qsel  <= w_qsel_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.fill_ready = (r_state == S_IDLE);
  assign bus.set_busy   = (r_state == S_FILL) && (bus.rd_set == r_fset);
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_qsel    = r_qsel;
  assign bus.wr_addr    = r_addr;
  assign bus.wr_data    = r_data;
  assign bus.fill_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_data_fill_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_fill_writer
// Description : Scoreboard bench for data_fill_writer: directed scenarios
//               followed by random fills, stores and read lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_fill_writer;
  localparam int SET_W = 10;
  localparam int WAY_W = 2;
  localparam int QW    = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_fill_writer_if #(.SET_W(SET_W), .WAY_W(WAY_W), .QW(QW)) bus ();

  data_fill_writer #(.SET_W(SET_W), .WAY_W(WAY_W), .QW(QW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0]  cyc;
    logic [11:0]  addr;
    logic [3:0]   qsel;
    logic [127:0] data;
    logic         done;
  } wr_t;

  wr_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  cyc     = 0;

  // Reference model: the line being filled and which quarter goes next
  bit           m_active = 1'b0;
  logic [127:0] m_q [4];
  int           m_next = 0;
  logic [9:0]   m_set = '0;
  logic [1:0]   m_way = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [511:0] rand512();
    return {rand128(), rand128(), rand128(), rand128()};
  endfunction

  // Monitor: every write on the port must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", bus.wr_en, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr",  bus.wr_addr, e.addr);
          check("wr_qsel",  bus.wr_qsel, e.qsel);
          check("wr_data",  bus.wr_data, e.data);
          check("fill_done", bus.fill_done, e.done);
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          check("missing_write", bus.wr_en, 1'b1);
          void'(exp_q.pop_front());
        end
        if (bus.fill_done !== 1'b0) check("done_without_write", bus.fill_done, 1'b0);
      end
    end
  end

  // One cycle of stimulus; the model predicts the write at the next edge
  task automatic drive(input bit fv, input logic [9:0] fs, input logic [1:0] fw,
                       input logic [511:0] fl, input bit sv, input logic [9:0] ss,
                       input logic [1:0] sw, input logic [1:0] sq,
                       input logic [127:0] sd, input logic [9:0] rs);
    bit was_active;
    wr_t e;
    @(posedge clk);
    #2;
    bus.fill_valid = fv; bus.fill_set = fs; bus.fill_way = fw; bus.fill_line = fl;
    bus.st_valid = sv; bus.st_set = ss; bus.st_way = sw; bus.st_qtr = sq; bus.st_data = sd;
    bus.rd_set = rs;
    #1;
    check("fill_ready", bus.fill_ready, !m_active);
    check("set_busy", bus.set_busy, m_active && (rs == m_set));

    was_active = m_active;
    if (sv) begin
      e.cyc = cyc + 1; e.addr = {ss, sw}; e.qsel = 4'(1 << sq); e.data = sd; e.done = 1'b0;
      exp_q.push_back(e);
      if (was_active && ss == m_set && sw == m_way) m_q[sq] = sd;
    end else if (was_active) begin
      e.cyc = cyc + 1; e.addr = {m_set, m_way}; e.qsel = 4'(1 << m_next);
      e.data = m_q[m_next]; e.done = (m_next == 3);
      exp_q.push_back(e);
      m_next++;
      if (m_next == 4) m_active = 1'b0;
    end
    if (!was_active && fv) begin
      m_active = 1'b1; m_set = fs; m_way = fw; m_next = 0;
      for (int q = 0; q < 4; q++) m_q[q] = fl[q*128 +: 128];
      if (sv && ss == fs && sw == fw) m_q[sq] = sd;
    end
  endtask

  task automatic idle(input int n, input logic [9:0] rs);
    for (int i = 0; i < n; i++) drive(0, '0, '0, '0, 0, '0, '0, '0, '0, rs);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.fill_valid = 0; bus.st_valid = 0; bus.rd_set = '0;
    m_active = 1'b0; m_next = 0;
    exp_q.delete();
    #1;
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_qsel", bus.wr_qsel, 4'b0000);
    check("rst_done", bus.fill_done, 1'b0);
    check("rst_ready", bus.fill_ready, 1'b1);
    check("rst_busy", bus.set_busy, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_wr_en", bus.wr_en, 1'b0);
    check("post_rst_qsel", bus.wr_qsel, 4'b0000);
    check("post_rst_addr", bus.wr_addr, 12'h000);
    check("post_rst_data", bus.wr_data, 128'h0);
  endtask

  initial begin
    logic [511:0] line;
    bit           fv, sv;
    logic [9:0]   fs, ss, rs;
    logic [1:0]   fw, sw, sq;

    bus.fill_valid = 0; bus.fill_set = '0; bus.fill_way = '0; bus.fill_line = '0;
    bus.st_valid = 0; bus.st_set = '0; bus.st_way = '0; bus.st_qtr = '0; bus.st_data = '0;
    bus.rd_set = '0;

    // Reset release and quiet idle
    do_reset();
    idle(3, 10'h155);

    // Plain fill of set 0x155 way 2, read side looking at the same set
    line = {128'hA3A3, 128'hA2A2, 128'hA1A1, 128'hA0A0};
    drive(1, 10'h155, 2'd2, line, 0, '0, '0, '0, '0, 10'h155);
    idle(4, 10'h155);
    idle(2, 10'h155);

    // Neighbouring set must not stall
    drive(1, 10'h155, 2'd2, rand512(), 0, '0, '0, '0, '0, 10'h156);
    idle(5, 10'h156);

    // Unrelated store during a fill defers the remaining beats
    drive(1, 10'h010, 2'd0, rand512(), 0, '0, '0, '0, '0, 10'h010);
    drive(0, '0, '0, '0, 1, 10'h003, 2'd1, 2'd2, 128'hD0D0_D0D0, 10'h010);
    idle(6, 10'h010);

    // Store into the line being filled overrides its quarter 3
    drive(1, 10'h020, 2'd3, rand512(), 0, '0, '0, '0, '0, 10'h020);
    drive(0, '0, '0, '0, 1, 10'h020, 2'd3, 2'd3, 128'h5555_AAAA, 10'h020);
    idle(6, 10'h000);

    // Store to the same line in the acceptance cycle replaces quarter 1
    drive(1, 10'h040, 2'd1, rand512(), 1, 10'h040, 2'd1, 2'd1, 128'hBEEF, 10'h040);
    drive(0, '0, '0, '0, 1, 10'h041, 2'd0, 2'd0, 128'hC0DE, 10'h040);
    drive(0, '0, '0, '0, 1, 10'h042, 2'd0, 2'd3, 128'hC1DE, 10'h040);
    idle(6, 10'h040);

    // Reset after two beats: nothing more may come out
    drive(1, 10'h077, 2'd1, rand512(), 0, '0, '0, '0, '0, 10'h077);
    idle(2, 10'h077);
    do_reset();
    idle(6, 10'h077);

    // Random traffic on a small set range so hits and merges are frequent
    for (int i = 0; i < 400; i++) begin
      fv = ($urandom_range(0, 2) == 0);
      fs = 10'($urandom_range(0, 3));
      fw = 2'($urandom_range(0, 3));
      sv = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        ss = m_set; sw = m_way;
      end else begin
        ss = 10'($urandom_range(0, 3)); sw = 2'($urandom_range(0, 3));
      end
      sq = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       rs = m_set;
        1:       rs = m_set + 10'd1;
        default: rs = 10'($urandom_range(0, 1023));
      endcase
      drive(fv, fs, fw, rand512(), sv, ss, sw, sq, rand128(), rs);
    end

    idle(10, 10'h000);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
